// File: rtl/reg_writeback_ctrl_if.sv
// Register-file writeback bundle: ALU and load-return sources, load-issue scoreboard
// queries, and the registered register-file write port.
interface reg_writeback_ctrl_if #(
  parameter int WIDTH       = 32,
  parameter int LOG2NUMREGS = 5,
  parameter int LOG2DEPTH   = 2
);
  logic                   alu_valid;
  logic [LOG2NUMREGS-1:0] alu_reg;
  logic [WIDTH-1:0]       alu_data;

  logic                   mem_valid;
  logic                   mem_ready;
  logic [LOG2NUMREGS-1:0] mem_reg;
  logic [WIDTH-1:0]       mem_data;

  logic                   ld_issue;
  logic [LOG2NUMREGS-1:0] ld_reg;

  logic [LOG2NUMREGS-1:0] q_a_reg;
  logic [LOG2NUMREGS-1:0] q_b_reg;
  logic                   q_a_busy;
  logic                   q_b_busy;

  logic [LOG2NUMREGS-1:0] c_reg;
  logic [WIDTH-1:0]       c_writedatain;
  logic                   c_we;
  logic [LOG2DEPTH:0]     fifo_count;

  modport master (
    output alu_valid, alu_reg, alu_data,
    output mem_valid, mem_reg, mem_data,
    output ld_issue, ld_reg,
    output q_a_reg, q_b_reg,
    input  mem_ready, q_a_busy, q_b_busy,
    input  c_reg, c_writedatain, c_we, fifo_count
  );

  modport slave (
    input  alu_valid, alu_reg, alu_data,
    input  mem_valid, mem_reg, mem_data,
    input  ld_issue, ld_reg,
    input  q_a_reg, q_b_reg,
    output mem_ready, q_a_busy, q_b_busy,
    output c_reg, c_writedatain, c_we, fifo_count
  );
endinterface

// File: rtl/reg_writeback_ctrl.sv
// Register-file write-port arbiter (ALU > load FIFO head > load bypass) with pending-load scoreboard.
// One-cycle registered write port; load returns stall via mem_ready only when the FIFO is full.
module reg_writeback_ctrl #(
  parameter int WIDTH       = 32,
  parameter int NUMREGS     = 32,
  parameter int LOG2NUMREGS = 5,
  parameter int DEPTH       = 4,
  parameter int LOG2DEPTH   = 2
) (
  input  logic                 clk,
  input  logic                 resetn,
  reg_writeback_ctrl_if.slave  bus
);

  localparam logic [LOG2DEPTH:0] FULL_CNT = (LOG2DEPTH+1)'(DEPTH);

  logic [LOG2NUMREGS-1:0] fifo_reg [DEPTH];
  logic [WIDTH-1:0]       fifo_dat [DEPTH];
  logic [LOG2DEPTH-1:0]   wr_ptr;
  logic [LOG2DEPTH-1:0]   rd_ptr;
  logic [LOG2DEPTH:0]     count;

  logic                   c_we_q;
  logic                   c_from_mem;
  logic [LOG2NUMREGS-1:0] c_reg_q;
  logic [WIDTH-1:0]       c_dat_q;

  logic [NUMREGS-1:0]     pending;
  logic [NUMREGS-1:0]     pending_nxt;

  logic                   mem_ready;
  logic                   fifo_empty;
  logic                   alu_sel;
  logic                   mem_take;
  logic                   pop;
  logic                   push;
  logic                   bypass;
  logic                   sel_we;
  logic                   sel_mem;
  logic [LOG2NUMREGS-1:0] sel_reg;
  logic [WIDTH-1:0]       sel_dat;

  // Ready depends on registered occupancy only, so a same-cycle pop cannot raise it.
  assign mem_ready  = (count != FULL_CNT);
  assign fifo_empty = (count == '0);
  assign alu_sel    = bus.alu_valid && (bus.alu_reg != '0);
  assign mem_take   = bus.mem_valid && mem_ready && (bus.mem_reg != '0);

  always_comb begin
    sel_we  = 1'b0;
    sel_mem = 1'b0;
    sel_reg = c_reg_q;
    sel_dat = c_dat_q;
    pop     = 1'b0;
    bypass  = 1'b0;
    if (alu_sel) begin
      sel_we  = 1'b1;
      sel_reg = bus.alu_reg;
      sel_dat = bus.alu_data;
    end else if (!fifo_empty) begin
      sel_we  = 1'b1;
      sel_mem = 1'b1;
      sel_reg = fifo_reg[rd_ptr];
      sel_dat = fifo_dat[rd_ptr];
      pop     = 1'b1;
    end else if (mem_take) begin
      sel_we  = 1'b1;
      sel_mem = 1'b1;
      sel_reg = bus.mem_reg;
      sel_dat = bus.mem_data;
      bypass  = 1'b1;
    end
  end

  // Bypass only happens with an empty FIFO, so acceptance order is preserved.
  assign push = mem_take && !bypass;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_reg[wr_ptr] <= bus.mem_reg;
      fifo_dat[wr_ptr] <= bus.mem_data;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      c_we_q     <= 1'b0;
      c_from_mem <= 1'b0;
      c_reg_q    <= '0;
      c_dat_q    <= '0;
    end else begin
      c_we_q     <= sel_we;
      c_from_mem <= sel_mem;
      c_reg_q    <= sel_reg;
      c_dat_q    <= sel_dat;
    end
  end

  // Clear lands on the edge the register file latches the load; a new issue to the same reg wins.
  always_comb begin
    pending_nxt = pending;
    if (c_we_q && c_from_mem) pending_nxt[c_reg_q] = 1'b0;
    if (bus.ld_issue && (bus.ld_reg != '0)) pending_nxt[bus.ld_reg] = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) pending <= '0;
    else         pending <= pending_nxt;
  end

  assign bus.mem_ready     = mem_ready;
  assign bus.fifo_count    = count;
  assign bus.c_we          = c_we_q;
  assign bus.c_reg         = c_reg_q;
  assign bus.c_writedatain = c_dat_q;
  assign bus.q_a_busy      = (bus.q_a_reg != '0) && pending[bus.q_a_reg];
  assign bus.q_b_busy      = (bus.q_b_reg != '0) && pending[bus.q_b_reg];

endmodule
